// File: rtl/fetch_pkg.sv
// Shared definitions for the Pillar instruction-fetch stage: state encoding,
// default reset PC and the alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ     = 2'd0,
    FETCH_ISSUE   = 2'd1,
    FETCH_WAIT_PC = 2'd2,
    FETCH_FAULT   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_slot.sv
// One-entry holding register for a next-PC strobe that arrives before fetch
// is ready to use it; later strobes overwrite, a consume clears it.
module fetch_pc_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_capture,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  output logic        o_full,
  output logic [31:0] o_pc
);

  logic        r_full;
  logic [31:0] r_pc;

  // Capture wins over clear; the owner never asserts both in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_pc   <= 32'h0000_0000;
    end else if (i_capture) begin
      r_full <= 1'b1;
      r_pc   <= i_pc;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_pc   = r_pc;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: one imem read per instruction, hands the word to
// decode, then waits for writeback's next PC. Misaligned next PC is terminal.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc_wd_i,
  input  logic               pc_valid_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [31:0]        imem_data_i,
  output logic [31:0]        ir_o,
  output logic [31:0]        pc_o,
  output logic               ir_valid_o,
  input  logic               ir_ready_i,
  output logic               fault_o,
  output logic [COUNT_W-1:0] fetch_count_o
);

  fetch_state_t       r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_ir;
  logic               r_ir_valid;
  logic               r_fault;
  logic [COUNT_W-1:0] r_count;

  logic        w_slot_full;
  logic [31:0] w_slot_pc;
  logic        w_capture;
  logic        w_clear;
  logic        w_have_pc;
  logic [31:0] w_next_pc;

  // Strobes seen before WAIT_PC are parked; FAULT ignores them entirely.
  assign w_capture = pc_valid_i &&
                     ((r_state == FETCH_REQ) || (r_state == FETCH_ISSUE));
  assign w_clear   = (r_state == FETCH_WAIT_PC);
  assign w_have_pc = pc_valid_i | w_slot_full;
  assign w_next_pc = pc_valid_i ? pc_wd_i : w_slot_pc;

  fetch_pc_slot u_pc_slot (
    .clk       (clk),
    .reset     (reset),
    .i_capture (w_capture),
    .i_clear   (w_clear),
    .i_pc      (pc_wd_i),
    .o_full    (w_slot_full),
    .o_pc      (w_slot_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= FETCH_REQ;
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0000_0000;
      r_ir_valid <= 1'b0;
      r_fault    <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        FETCH_REQ: begin
          if (imem_ack_i) begin
            r_ir       <= imem_data_i;
            r_ir_valid <= 1'b1;
            r_state    <= FETCH_ISSUE;
          end
        end
        FETCH_ISSUE: begin
          if (ir_ready_i) begin
            r_ir_valid <= 1'b0;
            r_count    <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            r_state    <= FETCH_WAIT_PC;
          end
        end
        FETCH_WAIT_PC: begin
          if (w_have_pc) begin
            if (pc_misaligned(w_next_pc)) begin
              r_fault <= 1'b1;
              r_state <= FETCH_FAULT;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= FETCH_REQ;
            end
          end
        end
        FETCH_FAULT: begin
          r_ir_valid <= 1'b0;
        end
        default: begin
          r_ir_valid <= 1'b0;
          r_fault    <= 1'b1;
          r_state    <= FETCH_FAULT;
        end
      endcase
    end
  end

  // Gated by reset so an outstanding request drops without waiting for a clock.
  assign imem_req_o    = (r_state == FETCH_REQ) & reset;
  assign imem_addr_o   = r_pc;
  assign pc_o          = r_pc;
  assign ir_o          = r_ir;
  assign ir_valid_o    = r_ir_valid;
  assign fault_o       = r_fault;
  assign fetch_count_o = r_count;

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage of the multi-cycle Pillar core; the consumer of the next-PC value produced by writeback.
- Holds the architectural PC and issues one instruction-memory read per instruction over a req/ack handshake.
- Presents the fetched word and its PC to decode on a valid/ready handshake, then waits for writeback's next PC before fetching again.
- Detects misaligned next-PC values and counts completed fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
- COUNT_W, 32, width of the fetch counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_wd_i  input  32  next PC from writeback.
- pc_valid_i  input  1  one-cycle strobe: pc_wd_i is valid.
- imem_req_o  output  1  read request to instruction memory.
- imem_addr_o  output  32  word-aligned read address.
- imem_ack_i  input  1  read data valid this cycle.
- imem_data_i  input  32  read data.
- ir_o  output  32  fetched instruction.
- pc_o  output  32  PC of ir_o.
- ir_valid_o  output  1  ir_o/pc_o valid for decode.
- ir_ready_i  input  1  decode accepts ir_o.
- fault_o  output  1  sticky misaligned-PC fault.
- fetch_count_o  output  COUNT_W  number of instructions accepted by decode.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=REQ, pc_o=RESET_PC, ir_o=0, ir_valid_o=0, fault_o=0, fetch_count_o=0, pending slot empty.
  - imem_req_o is driven combinationally from state, so it is 1 as soon as reset is released.
- State REQ:
  - imem_req_o=1 and imem_addr_o=pc_o, both held stable until imem_ack_i.
  - On imem_ack_i: ir_o<=imem_data_i, ir_valid_o<=1, go to ISSUE. ir_valid_o rises the cycle after ack (1-cycle latency).
- State ISSUE:
  - imem_req_o=0; ir_o and pc_o held stable while ir_valid_o=1.
  - On ir_ready_i: ir_valid_o<=0, fetch_count_o<=fetch_count_o+1 (wraps modulo 2^COUNT_W), go to WAIT_PC.
- State WAIT_PC:
  - Waits for a next PC, taken from pc_valid_i in this cycle or from the pending slot.
  - pc_wd_i[1:0]==0: pc_o<=pc_wd_i, go to REQ (the next request issues the following cycle).
  - pc_wd_i[1:0]!=0: fault_o<=1, go to FAULT; pc_o is left unchanged.
- State FAULT:
  - Terminal. imem_req_o=0, ir_valid_o=0, all inputs ignored.
  - Left only by reset.
- Pending slot (pc_valid_i outside WAIT_PC):
  - The PC is captured in a one-entry slot; a later strobe overwrites it (last wins).
  - On entering WAIT_PC with the slot full, the slot is consumed in that cycle and cleared, as if pc_valid_i arrived.
  - A live pc_valid_i in WAIT_PC takes priority over the slot and clears it.
- Simultaneous and stray events:
  - imem_ack_i outside REQ is ignored.
  - ir_ready_i outside ISSUE is ignored.
  - ir_ready_i in the same cycle ir_valid_o rises is fine; it is accepted on the following edge.
- Reset mid-transaction:
  - An outstanding request is abandoned and imem_req_o drops immediately (asynchronous).
  - The memory must tolerate a dropped request; a late ack is ignored unless state is REQ again.
- imem_addr_o equals pc_o in every state; it is only meaningful while imem_req_o=1.

Decomposition:
- Shared header alongside opcode.v (fetch_defs.v):
  - state encodings: FETCH_REQ=2'd0, FETCH_ISSUE=2'd1, FETCH_WAIT_PC=2'd2, FETCH_FAULT=2'd3.
  - default reset PC constant.
- One natural sub-module: fetch_pc_slot, the pending next-PC register with its capture, overwrite, consume and clear rules.

Test Plan:
- Reset release, RESET_PC=0 -> imem_req_o=1 with imem_addr_o=0 in the first post-reset cycle. Ack with data 32'h00500093 -> next cycle ir_valid_o=1, ir_o=32'h00500093, pc_o=0.
- Ack delayed 5 cycles -> imem_req_o and imem_addr_o held stable for all 5 cycles. Ack 2 cycles after that, while state=ISSUE -> ignored, ir_o unchanged.
- ir_ready_i held 0 for 3 cycles, then 1 -> ir_valid_o and ir_o stable throughout; fetch_count_o 0->1; pc_valid_i with pc_wd_i=32'h8 -> imem_addr_o=8 on the next request.
- pc_valid_i with 32'h10 while in ISSUE, then 32'h14 before ir_ready_i -> after acceptance the next fetch address is 32'h14, with no extra wait cycle.
- pc_wd_i=32'h6 in WAIT_PC -> fault_o=1 next cycle, imem_req_o stays 0 for 20+ cycles, later pc_valid_i ignored. reset=0 -> fault_o=0, fetch restarts at RESET_PC.
- Preload fetch_count_o to 2^32-1 via repeated fetches or a forced value; accept one more -> fetch_count_o=0. Assert reset mid-REQ -> imem_req_o drops in the same cycle.
